// File: rtl/load_register.sv
// Generic edge-triggered storage register with synchronous load, synchronous
// active-high reset and a tri-state output. It is shared by many models.
`ifndef LOAD_REGISTER_SV
`define LOAD_REGISTER_SV

module load_register #(
  parameter int unsigned      DATA_WIDTH  = 8,
  parameter logic [63:0]      RESET_VALUE = 64'd0
) (
  input  logic                  clock,
  input  logic                  load,
  input  logic                  reset,
  input  logic                  oe,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  localparam logic [DATA_WIDTH-1:0] ResetWord = RESET_VALUE[DATA_WIDTH-1:0];

  logic [DATA_WIDTH-1:0] r_stored;

  // Reset has priority over load; with neither asserted the word holds.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_stored <= ResetWord;
    end else if (load) begin
      r_stored <= d;
    end
  end

  assign q = oe ? r_stored : {DATA_WIDTH{1'bz}};

endmodule

`endif

// File: tb/tb_load_register.sv
// Directed self-checking bench for load_register (13-bit, reset value 0x0A5).
// The output bus is pulled up so a released bus reads as all ones.
`include "rtl/load_register.sv"

module tb_load_register;

  localparam int unsigned W = 13;

  logic         clock;
  logic         load;
  logic         reset;
  logic         oe;
  logic [W-1:0] d;
  wire  [W-1:0] qBus;

  int passedChecks;
  int totalChecks;

  pullup (qBus);

  load_register #(
    .DATA_WIDTH (W),
    .RESET_VALUE(64'h0A5)
  ) dut (
    .clock(clock),
    .load (load),
    .reset(reset),
    .oe   (oe),
    .d    (d),
    .q    (qBus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Set the controls, then let one rising edge pass and settle 1 time unit after it.
  task automatic applyStimulus(input logic rst, input logic ld, input logic [W-1:0] data);
    reset = rst;
    load  = ld;
    d     = data;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [W-1:0] expected);
    totalChecks++;
    assert (qBus === expected) passedChecks++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, qBus, expected);
  endtask

  initial begin
    passedChecks = 0;
    totalChecks  = 0;
    oe    = 1'b1;
    load  = 1'b0;
    reset = 1'b0;
    d     = '0;
    #1;

    applyStimulus(1'b0, 1'b0, 13'h0000);
    applyStimulus(1'b0, 1'b1, 13'h0000);
    checkOutput("first_load_zero", 13'h0000);

    applyStimulus(1'b1, 1'b0, 13'h1111);
    checkOutput("reset_value", 13'h00A5);

    applyStimulus(1'b0, 1'b1, 13'h1ABC);
    checkOutput("load_1abc", 13'h1ABC);
    applyStimulus(1'b0, 1'b0, 13'h0555);
    checkOutput("hold_no_load", 13'h1ABC);

    applyStimulus(1'b0, 1'b1, 13'h1FFF);
    checkOutput("load_1fff", 13'h1FFF);
    applyStimulus(1'b1, 1'b1, 13'h0123);
    checkOutput("reset_beats_load", 13'h00A5);
    applyStimulus(1'b0, 1'b1, 13'h0123);
    checkOutput("load_after_reset", 13'h0123);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 13'h1234 + 13'(i));
      checkOutput($sformatf("reset_load_held_%0d", i), 13'h00A5);
    end

    applyStimulus(1'b0, 1'b1, 13'h0042);
    checkOutput("oe_on_before", 13'h0042);
    oe = 1'b0;
    #1;
    checkOutput("oe_off_released", 13'h1FFF);
    oe = 1'b1;
    #1;
    checkOutput("oe_on_again", 13'h0042);

    oe = 1'b0;
    applyStimulus(1'b0, 1'b1, 13'h0777);
    checkOutput("load_while_off", 13'h1FFF);
    applyStimulus(1'b0, 1'b0, 13'h0000);
    oe = 1'b1;
    #1;
    checkOutput("load_while_off_seen", 13'h0777);

    oe = 1'b0;
    applyStimulus(1'b0, 1'b0, 13'h0ABC);
    oe = 1'b1;
    #1;
    checkOutput("oe_does_not_store", 13'h0777);

    for (int i = 0; i <= 20; i++) begin
      applyStimulus(1'b0, 1'b1, 13'(i));
      checkOutput($sformatf("stream_%0d", i), 13'(i));
    end

    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b0, 1'b1, 13'h1FFC + 13'(i));
      checkOutput($sformatf("wrap_%0d", i), 13'h1FFC + 13'(i));
    end

    $display("%0d/%0d checks passed", passedChecks, totalChecks);
    $finish;
  end

endmodule
